arm_trace_monitor: RTL and testbench

ARM_TRACE_MONITOR -- requirements
Module: arm_trace_monitor

---
 rtl/arm_trace_monitor.sv | 156 +++++++++++++++
 tb/tb_arm_trace_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_trace_monitor.sv
// arm_trace_monitor: shadows the core's architectural register writes and
// queues retirement events (register writebacks, optionally memory stores)
// into a trace FIFO with a valid/ready drain port, overflow flag and a
// saturating drop counter. NDBG debug channels read the shadow registers.
// Optional feature macro: TRACE_MEM_EN (trace memory stores as well).
module arm_trace_monitor #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int DEPTH = 8,
  parameter int NDBG  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           PC,
  input  logic                       RegWrite,
  input  logic                       MemtoReg,
  input  logic                       MemWrite,
  input  logic [3:0]                 A3,
  input  logic [WIDTH-1:0]           ALUResult,
  input  logic [WIDTH-1:0]           ReadData,
  input  logic [WIDTH-1:0]           WriteData,
  input  logic                       trace_en,
  input  logic                       ovf_clr,
  input  logic [NDBG*4-1:0]          dbg_sel,
  output logic [NDBG*WIDTH-1:0]      dbg_val,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic                       tr_kind,
  output logic [3:0]                 tr_tag,
  output logic [WIDTH-1:0]           tr_pc,
  output logic [WIDTH-1:0]           tr_addr,
  output logic [WIDTH-1:0]           tr_data,
  output logic [$clog2(DEPTH+1)-1:0] tr_count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic             kind;
    logic [3:0]       tag;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           fifo [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  // 16 slots so any 4-bit index is in range; slots >= NREGS are never written
  logic [WIDTH-1:0] shadow [16];

  logic [WIDTH-1:0] wb;
  logic             reg_ev, mem_ev, pop, push, room;
  logic [1:0]       drops;
  logic [8:0]       dsum;
  entry_t           new_e, head;

  assign wb     = MemtoReg ? ReadData : ALUResult;
  assign reg_ev = RegWrite && ({1'b0, A3} < 5'(NREGS));

`ifdef TRACE_MEM_EN
  assign mem_ev = MemWrite;
`else
  logic unused_mem;
  assign mem_ev     = 1'b0;
  assign unused_mem = ^{MemWrite, WriteData};
`endif

  // push/pop decision, new entry formation and per-cycle drop tally
  always_comb begin
    pop    = tr_valid && tr_ready;
    room   = (tr_count != CW'(DEPTH)) || pop;
    push   = trace_en && (reg_ev || mem_ev) && room;
    new_e  = '0;
    new_e.pc = PC;
    if (reg_ev) begin
      new_e.tag  = A3;
      new_e.data = wb;
    end
`ifdef TRACE_MEM_EN
    else begin
      new_e.kind = 1'b1;
      new_e.addr = ALUResult;
      new_e.data = WriteData;
    end
`endif
    // each discarded event counts once; a store losing to a register
    // writeback is a drop even when there is room
    drops = 2'd0;
    if (trace_en) begin
      if (!room)                drops = 2'(reg_ev) + 2'(mem_ev);
      else if (reg_ev && mem_ev) drops = 2'd1;
    end
    dsum = (ovf_clr ? 9'd0 : {1'b0, drop_cnt}) + 9'(drops);
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      tr_count <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= new_e;
        wptr       <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop)      tr_count <= tr_count + CW'(1);
      else if (pop && !push) tr_count <= tr_count - CW'(1);
    end
  end

  // sticky overflow and saturating drop counter; a drop beats a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drops != 2'd0) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
      if (drops != 2'd0 || ovf_clr) drop_cnt <= dsum[8] ? 8'hFF : dsum[7:0];
    end
  end

  // shadow register file follows every in-range writeback, traced or not
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else if (reg_ev) begin
      shadow[A3] <= wb;
    end
  end

  // head entry is masked to zero whenever the queue is empty
  assign head     = fifo[rptr];
  assign tr_valid = (tr_count != '0);
  assign tr_tag   = tr_valid ? head.tag  : 4'd0;
  assign tr_pc    = tr_valid ? head.pc   : '0;
  assign tr_data  = tr_valid ? head.data : '0;
`ifdef TRACE_MEM_EN
  assign tr_kind  = tr_valid ? head.kind : 1'b0;
  assign tr_addr  = tr_valid ? head.addr : '0;
`else
  assign tr_kind  = 1'b0;
  assign tr_addr  = '0;
`endif

  // debug read channels, out-of-range index reads as zero
  for (genvar i = 0; i < NDBG; i++) begin : g_dbg
    logic [3:0] sel;
    assign sel = dbg_sel[4*i +: 4];
    assign dbg_val[WIDTH*i +: WIDTH] = ({1'b0, sel} < 5'(NREGS)) ? shadow[sel] : '0;
  end
endmodule

// File: tb/tb_arm_trace_monitor.sv
// Self-checking bench for arm_trace_monitor: queue-based reference model,
// per-cycle compare process, directed scenarios with literal expectations,
// then a randomized soak.
module tb_arm_trace_monitor;
  localparam int WIDTH = 32;
  localparam int NREGS = 12;
  localparam int DEPTH = 8;
  localparam int NDBG  = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef TRACE_MEM_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, RegWrite, MemtoReg, MemWrite, trace_en, ovf_clr, tr_ready;
  logic [WIDTH-1:0] PC, ALUResult, ReadData, WriteData;
  logic [3:0] A3;
  logic [NDBG*4-1:0] dbg_sel;
  logic [NDBG*WIDTH-1:0] dbg_val;
  logic tr_valid, tr_kind, overflow;
  logic [3:0] tr_tag;
  logic [WIDTH-1:0] tr_pc, tr_addr, tr_data;
  logic [CW-1:0] tr_count;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  arm_trace_monitor #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH), .NDBG(NDBG)) dut (
    .clk(clk), .reset(reset), .PC(PC), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .A3(A3), .ALUResult(ALUResult), .ReadData(ReadData),
    .WriteData(WriteData), .trace_en(trace_en), .ovf_clr(ovf_clr), .dbg_sel(dbg_sel),
    .dbg_val(dbg_val), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind),
    .tr_tag(tr_tag), .tr_pc(tr_pc), .tr_addr(tr_addr), .tr_data(tr_data),
    .tr_count(tr_count), .overflow(overflow), .drop_cnt(drop_cnt));

  typedef struct {
    logic        kind;
    logic [3:0]  tag;
    logic [31:0] pc, addr, data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] sh [16];
  bit          m_ovf;
  int          m_dcnt;
  int          n_chk = 0, n_fail = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one transaction per rising edge, from the rules directly
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf = 0;
      m_dcnt = 0;
      for (int i = 0; i < 16; i++) sh[i] = '0;
    end else begin
      bit rev, mev, pop;
      int nd;
      logic [31:0] wbv;
      ent_t e;
      wbv = MemtoReg ? ReadData : ALUResult;
      rev = RegWrite && (int'(A3) < NREGS);
      mev = MEM_EN && MemWrite;
      pop = (q.size() != 0) && tr_ready;
      nd = 0;
      if (pop) void'(q.pop_front());
      if (trace_en && (rev || mev)) begin
        if (q.size() < DEPTH) begin
          if (rev) e = '{1'b0, A3, PC, 32'h0, wbv};
          else     e = '{1'b1, 4'h0, PC, ALUResult, WriteData};
          q.push_back(e);
          if (rev && mev) nd = 1;
        end else begin
          nd = int'(rev) + int'(mev);
        end
      end
      if (ovf_clr) begin m_ovf = 0; m_dcnt = 0; end
      if (nd != 0) begin
        m_ovf = 1;
        m_dcnt = (m_dcnt + nd > 255) ? 255 : m_dcnt + nd;
      end
      if (rev) sh[A3] = wbv;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("tr_count", 64'(tr_count), 64'(q.size()));
      check("tr_valid", 64'(tr_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("tr_kind", 64'(tr_kind), 64'(q[0].kind));
        check("tr_tag",  64'(tr_tag),  64'(q[0].tag));
        check("tr_pc",   64'(tr_pc),   64'(q[0].pc));
        check("tr_addr", 64'(tr_addr), 64'(q[0].addr));
        check("tr_data", 64'(tr_data), 64'(q[0].data));
      end else begin
        check("tr_empty_fields", {tr_kind, tr_tag, tr_pc, tr_addr[26:0]}, 64'h0);
        check("tr_empty_data", 64'(tr_data), 64'h0);
      end
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("drop_cnt", 64'(drop_cnt), 64'(m_dcnt));
      for (int c = 0; c < NDBG; c++) begin
        int s;
        s = int'(dbg_sel[4*c +: 4]);
        check("dbg_val", 64'(dbg_val[WIDTH*c +: WIDTH]), 64'((s < NREGS) ? sh[s] : 32'h0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 0; MemWrite = 0; MemtoReg = 0; ovf_clr = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle(); step(); reset = 0;
  endtask

  task automatic rev(input logic [3:0] a, input logic [31:0] v, input logic [31:0] p);
    RegWrite = 1; A3 = a; ALUResult = v; MemtoReg = 0; PC = p;
  endtask

  initial begin
    reset = 1; RegWrite = 0; MemtoReg = 0; MemWrite = 0; A3 = 0;
    PC = 0; ALUResult = 0; ReadData = 0; WriteData = 0;
    trace_en = 0; ovf_clr = 0; tr_ready = 0; dbg_sel = '0;
    step(); step();
    reset = 0;
    chk_en = 1;
    check("rst_count", 64'(tr_count), 64'h0);
    check("rst_ovf", {overflow, drop_cnt}, 64'h0);
    check("rst_dbg", 64'(dbg_val[63:0]), 64'h0);

    // single register event, visible the next cycle
    trace_en = 1; tr_ready = 0; dbg_sel = 16'h0002;
    rev(4'd2, 32'h55, 32'h8);
    step(); idle();
    check("first_valid", 64'(tr_valid), 64'h1);
    check("first_tag", 64'(tr_tag), 64'h2);
    check("first_data", 64'(tr_data), 64'h55);
    check("first_pc", 64'(tr_pc), 64'h8);
    check("first_dbg", 64'(dbg_val[31:0]), 64'h55);

    // 10 events into a stalled 8-deep FIFO, then drain in order
    do_reset();
    trace_en = 1; tr_ready = 0;
    for (int i = 0; i < 10; i++) begin
      rev(4'(i), 32'h100 + 32'(i), 32'(4*i));
      step();
    end
    idle();
    check("ovf_count", 64'(tr_count), 64'h8);
    check("ovf_flag", 64'(overflow), 64'h1);
    check("ovf_drops", 64'(drop_cnt), 64'h2);
    tr_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("drain_data", 64'(tr_data), 64'h100 + 64'(i));
      step();
    end
    check("drain_empty", 64'(tr_valid), 64'h0);

    // full FIFO with simultaneous pop and push
    do_reset();
    trace_en = 1; tr_ready = 0;
    for (int i = 0; i < 8; i++) begin rev(4'(i), 32'h200 + 32'(i), 32'h0); step(); end
    tr_ready = 1; rev(4'd9, 32'h2FF, 32'h40);
    step(); idle(); tr_ready = 0;
    check("full_pp_count", 64'(tr_count), 64'h8);
    check("full_pp_ovf", 64'(overflow), 64'h0);
    check("full_pp_head", 64'(tr_data), 64'h201);

    // drop and clear in the same cycle: drop wins, counter restarts at 1
    rev(4'd1, 32'h1, 32'h0); step();
    rev(4'd1, 32'h2, 32'h0); step(); idle();
    check("pre_clr_drops", 64'(drop_cnt), 64'h2);
    ovf_clr = 1; rev(4'd1, 32'h3, 32'h0); step(); idle();
    check("clr_drop_wins", {overflow, drop_cnt}, 64'h101);
    ovf_clr = 1; step(); idle();
    check("clr_only", {overflow, drop_cnt}, 64'h0);

    // saturation of the drop counter
    for (int i = 0; i < 300; i++) begin rev(4'(i % NREGS), 32'(i), 32'(i)); step(); end
    idle();
    check("drop_sat", 64'(drop_cnt), 64'hFF);

    // register and memory events together
    do_reset();
    trace_en = 1; tr_ready = 0;
    rev(4'd4, 32'hAB, 32'h10); MemWrite = 1; WriteData = 32'hCD;
    step(); idle();
    check("collide_count", 64'(tr_count), 64'h1);
    check("collide_kind", 64'(tr_kind), 64'h0);
    check("collide_drop", 64'(drop_cnt), MEM_EN ? 64'h1 : 64'h0);

    // trace disabled still shadows; MemtoReg selects ReadData; A3 >= NREGS ignored
    do_reset();
    trace_en = 0; dbg_sel = 16'hC070;
    rev(4'd7, 32'h1234, 32'h0); step(); idle();
    check("dis_count", 64'(tr_count), 64'h0);
    check("dis_dbg", 64'(dbg_val[63:32]), 64'h1234);
    rev(4'd7, 32'h1, 32'h0); MemtoReg = 1; ReadData = 32'hBEEF; step(); idle();
    check("memtoreg_dbg", 64'(dbg_val[63:32]), 64'hBEEF);
    rev(4'd12, 32'h99, 32'h0); step(); idle();
    check("oor_dbg", 64'(dbg_val[127:96]), 64'h0);

    // reset mid-operation with five queued, event in the reset cycle ignored
    trace_en = 1; tr_ready = 0;
    for (int i = 0; i < 5; i++) begin rev(4'(i), 32'h300 + 32'(i), 32'h0); step(); end
    idle();
    check("pre_rst_count", 64'(tr_count), 64'h5);
    dbg_sel = 16'h3210;
    reset = 1; rev(4'd3, 32'h77, 32'h0); step(); reset = 0; idle();
    check("midrst_count", 64'(tr_count), 64'h0);
    check("midrst_ovf", 64'(overflow), 64'h0);
    check("midrst_dbg", dbg_val[63:0] | dbg_val[127:64], 64'h0);

    // randomized soak
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      trace_en  = ($urandom_range(0, 9) < 8);
      tr_ready  = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 5 : 2));
      RegWrite  = ($urandom_range(0, 9) < 6);
      MemWrite  = ($urandom_range(0, 9) < 3);
      MemtoReg  = $urandom_range(0, 1);
      A3        = 4'($urandom_range(0, 15));
      PC        = $urandom; ALUResult = $urandom; ReadData = $urandom; WriteData = $urandom;
      ovf_clr   = ($urandom_range(0, 39) == 0);
      dbg_sel   = 16'($urandom);
      step();
    end
    reset = 0; idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
